// File: rtl/decoder_pkg.sv
// Shared types for the decoder pipeline: decode-mode encoding and buffer depth.
package decoder_pkg;

    typedef enum logic [1:0] {
        DEC_ONEHOT  = 2'd0,
        DEC_THERMO  = 2'd1,
        DEC_ONECOLD = 2'd2,
        DEC_RSVD    = 2'd3
    } decode_mode_e;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/decoder_pipe_core.sv
// Combinational (idx, mode) -> (code, err) decoder.
module decoder_core
    import decoder_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int OUT_N = 8
) (
    input  logic [IN_W-1:0]  i_idx,
    input  decode_mode_e     i_mode,
    output logic [OUT_N-1:0] o_code,
    output logic             o_err
);

    logic [IN_W:0]    w_idx_ext;
    logic [OUT_N-1:0] w_onehot;
    logic [OUT_N-1:0] w_thermo;
    logic             w_oor;

    localparam logic [IN_W:0] LP_N = (IN_W + 1)'(OUT_N);

    assign w_idx_ext = {1'b0, i_idx};
    // Never true when OUT_N == 2^IN_W, so only the reserved mode can flag then.
    assign w_oor     = (w_idx_ext >= LP_N);

    for (genvar gi = 0; gi < OUT_N; gi++) begin : g_bit
        localparam logic [IN_W:0] LP_GI = (IN_W + 1)'(gi);
        assign w_onehot[gi] = (w_idx_ext == LP_GI);
        assign w_thermo[gi] = (w_idx_ext >= LP_GI);
    end

    always_comb begin
        o_code = '0;
        o_err  = 1'b0;
        if (i_mode == DEC_RSVD) begin
            o_err = 1'b1;
        end else if (w_oor) begin
            o_err  = 1'b1;
            o_code = (i_mode == DEC_ONEHOT) ? '0 : '1;
        end else begin
            case (i_mode)
                DEC_ONEHOT:  o_code = w_onehot;
                DEC_THERMO:  o_code = w_thermo;
                DEC_ONECOLD: o_code = ~w_onehot;
                default:     o_code = '0;
            endcase
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// Binary-to-code decoder with a 2-entry elastic output buffer and a
// saturating error counter.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int OUT_N = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_idx,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_N-1:0] out_code,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_cnt
);

    if (OUT_N < 2 || OUT_N > (1 << IN_W)) begin : g_bad_param
        $error("decoder_pipe: OUT_N must lie in 2..2^IN_W");
    end

    typedef struct packed {
        logic [OUT_N-1:0] code;
        logic             err;
    } entry_t;

    localparam logic [1:0]       LP_FULL    = 2'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

    entry_t           r_mem [FIFO_DEPTH];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_err_cnt;

    entry_t           w_entry_in;
    logic             w_push;
    logic             w_pop;

    decoder_core #(
        .IN_W  (IN_W),
        .OUT_N (OUT_N)
    ) u_core (
        .i_idx  (in_idx),
        .i_mode (decode_mode_e'(in_mode)),
        .o_code (w_entry_in.code),
        .o_err  (w_entry_in.err)
    );

    // Handshake flags depend only on registered occupancy.
    assign in_ready  = (r_count != LP_FULL);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign out_code  = r_mem[r_rd_ptr].code;
    assign out_err   = r_mem[r_rd_ptr].err;
    assign err_cnt   = r_err_cnt;

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mem[gi] <= '0;
            end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                r_mem[gi] <= w_entry_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear wins over a same-cycle erroneous accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_push && w_entry_in.err && (r_err_cnt != LP_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed self-checking bench for decoder_pipe (default, OUT_N=6 and CNT_W=2 instances).
module tb_decoder_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: defaults
    logic       a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_out_err, a_clr = 0;
    logic [2:0] a_idx = 0;
    logic [1:0] a_mode = 0;
    logic [7:0] a_code, a_cnt;

    // Instance B: OUT_N=6
    logic       b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_out_err, b_clr = 0;
    logic [2:0] b_idx = 0;
    logic [1:0] b_mode = 0;
    logic [5:0] b_code;
    logic [7:0] b_cnt;

    // Instance C: CNT_W=2
    logic       c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 1, c_out_err, c_clr = 0;
    logic [2:0] c_idx = 0;
    logic [1:0] c_mode = 0;
    logic [7:0] c_code;
    logic [1:0] c_cnt;

    decoder_pipe #(.IN_W(3), .OUT_N(8), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_idx(a_idx), .in_mode(a_mode), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_code(a_code), .out_err(a_out_err), .err_cnt(a_cnt), .clr_cnt(a_clr)
    );

    decoder_pipe #(.IN_W(3), .OUT_N(6), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_idx(b_idx), .in_mode(b_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_code(b_code), .out_err(b_out_err), .err_cnt(b_cnt), .clr_cnt(b_clr)
    );

    decoder_pipe #(.IN_W(3), .OUT_N(8), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_idx(c_idx), .in_mode(c_mode), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_code(c_code), .out_err(c_out_err), .err_cnt(c_cnt), .clr_cnt(c_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(a_in_ready),  32'h1);
        check("rst_out_valid", 32'(a_out_valid), 32'h0);
        check("rst_out_code",  32'(a_code),      32'h0);
        check("rst_out_err",   32'(a_out_err),   32'h0);
        check("rst_err_cnt",   32'(a_cnt),       32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single accept idx=5 one-hot
        a_in_valid = 1; a_idx = 5; a_mode = 0;
        @(negedge clk);
        a_in_valid = 0;
        check("single_valid", 32'(a_out_valid), 32'h1);
        check("single_code",  32'(a_code),      32'h20);
        check("single_err",   32'(a_out_err),   32'h0);
        @(negedge clk);
        check("single_drained", 32'(a_out_valid), 32'h0);

        // Back-to-back thermometer 0,3,7
        a_in_valid = 1; a_idx = 0; a_mode = 1;
        @(negedge clk);
        check("thermo0_code",  32'(a_code),     32'h01);
        check("thermo0_ready", 32'(a_in_ready), 32'h1);
        a_idx = 3;
        @(negedge clk);
        check("thermo3_code",  32'(a_code),     32'h0F);
        check("thermo3_ready", 32'(a_in_ready), 32'h1);
        a_idx = 7;
        @(negedge clk);
        check("thermo7_code",  32'(a_code),     32'hFF);
        check("thermo7_ready", 32'(a_in_ready), 32'h1);
        a_in_valid = 0;
        @(negedge clk);
        check("thermo_drained", 32'(a_out_valid), 32'h0);

        // Fill under stall: idx=2 one-cold, then idx=6 one-hot
        a_out_ready = 0;
        a_in_valid = 1; a_idx = 2; a_mode = 2;
        @(negedge clk);
        check("stall1_code",  32'(a_code),     32'hFB);
        check("stall1_ready", 32'(a_in_ready), 32'h1);
        a_idx = 6; a_mode = 0;
        @(negedge clk);
        a_in_valid = 0;
        check("stall2_ready", 32'(a_in_ready), 32'h0);
        check("stall2_code",  32'(a_code),     32'hFB);
        @(negedge clk);
        check("stall_hold_code",  32'(a_code),      32'hFB);
        check("stall_hold_err",   32'(a_out_err),   32'h0);
        check("stall_hold_valid", 32'(a_out_valid), 32'h1);
        a_out_ready = 1;
        @(negedge clk);
        check("drain2_code",  32'(a_code),      32'h40);
        check("drain2_valid", 32'(a_out_valid), 32'h1);
        check("drain2_ready", 32'(a_in_ready),  32'h1);
        @(negedge clk);
        check("drain_empty", 32'(a_out_valid), 32'h0);
        check("a_cnt_clean", 32'(a_cnt),       32'h0);

        // OUT_N=6: out-of-range in one-hot and thermometer, then clear beats reserved mode
        b_in_valid = 1; b_idx = 6; b_mode = 0;
        @(negedge clk);
        check("b_oor_onehot_code", 32'(b_code),    32'h00);
        check("b_oor_onehot_err",  32'(b_out_err), 32'h1);
        check("b_cnt1",            32'(b_cnt),     32'h1);
        b_idx = 7; b_mode = 1;
        @(negedge clk);
        check("b_oor_thermo_code", 32'(b_code),    32'h3F);
        check("b_oor_thermo_err",  32'(b_out_err), 32'h1);
        check("b_cnt2",            32'(b_cnt),     32'h2);
        b_idx = 0; b_mode = 3; b_clr = 1;
        @(negedge clk);
        check("b_rsvd_code", 32'(b_code),    32'h00);
        check("b_rsvd_err",  32'(b_out_err), 32'h1);
        check("b_cnt_clr",   32'(b_cnt),     32'h0);
        b_clr = 0; b_idx = 5; b_mode = 2;
        @(negedge clk);
        b_in_valid = 0;
        check("b_edge_onecold_code", 32'(b_code),    32'h1F);
        check("b_edge_onecold_err",  32'(b_out_err), 32'h0);
        check("b_cnt_stays",         32'(b_cnt),     32'h0);

        // CNT_W=2 saturation over five erroneous accepts
        c_in_valid = 1; c_mode = 3;
        for (int k = 0; k < 5; k++) begin
            c_idx = 3'(k);
            @(negedge clk);
            check($sformatf("c_sat_%0d", k), 32'(c_cnt), (k < 3) ? 32'(k + 1) : 32'h3);
        end
        c_in_valid = 0;

        // Reset mid-operation with two buffered entries (second uses reserved mode)
        a_out_ready = 0;
        a_in_valid = 1; a_idx = 1; a_mode = 0;
        @(negedge clk);
        a_mode = 3; a_idx = 4;
        @(negedge clk);
        a_in_valid = 0;
        check("full_ready", 32'(a_in_ready), 32'h0);
        check("full_head",  32'(a_code),     32'h02);
        check("full_cnt",   32'(a_cnt),      32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(a_out_valid), 32'h0);
        check("arst_code",  32'(a_code),      32'h0);
        check("arst_err",   32'(a_out_err),   32'h0);
        check("arst_cnt",   32'(a_cnt),       32'h0);
        rst_n = 1'b1;
        a_out_ready = 1;
        @(negedge clk);
        check("arst_ready_after", 32'(a_in_ready),  32'h1);
        check("arst_valid_after", 32'(a_out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Parametrised binary-to-code decoder with a 2-entry elastic output buffer and valid/ready handshakes on both sides.
- Supports one-hot, thermometer and one-cold output modes, selected per transaction.
- Flags out-of-range indices and reserved modes, and keeps a saturating error count.
- Used as the generic select/enable generator in front of banked or multi-channel datapaths.

Parameters:
IN_W, 3, width of the binary index input
OUT_N, 8, number of output lines; legal range 2..2^IN_W
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock; rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  buffer can accept a transaction
in_idx  input  IN_W  binary index to decode
in_mode  input  2  0=one-hot, 1=thermometer, 2=one-cold, 3=reserved
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts the head entry
out_code  output  OUT_N  decoded code of the head entry
out_err  output  1  head entry was out-of-range or used reserved mode
err_cnt  output  CNT_W  saturating count of accepted erroneous transactions
clr_cnt  input  1  synchronous clear of err_cnt

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset state: occupancy=0, in_ready=1, out_valid=0, out_code=0, out_err=0, err_cnt=0. Storage contents are don't-care but must be driven to 0.
- Decode is combinational on in_idx/in_mode and is written into the buffer on accept (accept = in_valid & in_ready).
  - mode 0, idx<OUT_N: bit idx=1, all other bits 0.
  - mode 1, idx<OUT_N: bits 0..idx=1, all bits above idx=0.
  - mode 2, idx<OUT_N: bit idx=0, all other bits 1.
  - idx>=OUT_N in mode 0: code all-0, err=1.
  - idx>=OUT_N in mode 1 or 2: code all-1, err=1.
  - mode 3, any idx: code all-0, err=1.
- Buffer: 2-entry FIFO, occupancy 0..2.
  - in_ready = (occupancy<2), driven from registered state only; no combinational path from out_ready.
  - out_valid = (occupancy>0); out_code and out_err always come from the head entry.
  - Pop = out_valid & out_ready.
  - Push without pop: occupancy+1. Pop without push: occupancy-1. Simultaneous push and pop at occupancy 1: occupancy stays 1 and the new entry becomes head next cycle.
  - Push is impossible at occupancy 2.
- Latency: accept in cycle t gives out_valid in cycle t+1 when the buffer was empty.
- Throughput: one transaction per cycle sustained while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, out_code and out_err stay stable.
- Ordering: strict FIFO; no drop or duplication.
- err_cnt:
  - +1 on each accepted transaction with err=1, saturating at 2^CNT_W-1.
  - clr_cnt has priority over increment: clr in the same cycle as an erroneous accept gives 0.
  - Counting is on accept, not pop.
- Reset mid-operation: buffered entries are discarded immediately; outputs return to their reset values asynchronously.
- OUT_N=2^IN_W: out-of-range cannot occur; only mode 3 raises err.
- Elaboration-time check: OUT_N outside 2..2^IN_W is an error.

Decomposition:
- Package decoder_pkg holds:
  - enum decode_mode_e {DEC_ONEHOT, DEC_THERMO, DEC_ONECOLD, DEC_RSVD}
  - entry struct {code, err}, parameterised via the module
- Sub-module decoder_core: purely combinational (idx, mode) -> (code, err), parametrised by IN_W/OUT_N.
- The FIFO and counter live in decoder_pipe.

Test Plan:
- Reset then single accept, idx=5, mode 0, out_ready=1 (defaults) -> next cycle out_valid=1, out_code=8'b0010_0000, out_err=0; occupancy back to 0 after pop.
- Back-to-back idx=0,3,7 in mode 1 with out_ready=1 -> consecutive cycles 8'b0000_0001, 8'b0000_1111, 8'b1111_1111; in_ready stays 1 throughout.
- out_ready=0, push idx=2 mode 2 then idx=6 mode 0 -> in_ready=0 after the 2nd accept, head held at 8'b1111_1011; after out_ready=1 the outputs are 8'b1111_1011 then 8'b0100_0000.
- OUT_N=6 instance: idx=6 mode 0 -> code 6'b000000, err=1; idx=7 mode 1 -> 6'b111111, err=1; err_cnt=2. Then mode 3 with clr_cnt=1 in the same cycle -> err_cnt=0.
- CNT_W=2, five erroneous accepts -> err_cnt sequence 1,2,3,3,3.
- Buffer holds 2 entries, rst_n pulsed low mid-cycle -> out_valid=0, out_code=0, err_cnt=0 immediately; in_ready=1 after release.
